// File: rtl/ram_arbiter.sv
// ram_arbiter
//   Shares one asynchronous 32-bit SRAM between an instruction-fetch port and
//   a data port. The data port has fixed priority. Each access is one IDLE
//   grant cycle, WAIT_CYCLES strobe cycles (ACCESS) and one RECOVER cycle.
//   The access completes in RECOVER with a one-cycle ack pulse.
//
// Handshake: a requester raises *_ce_i and holds its address and data stable
//   until it is sampled in IDLE. Everything is latched at that grant edge, so
//   the request may drop afterwards without affecting the access. The *_ack_o
//   pulse marks completion, and read data is valid on *_data_o from that
//   cycle on. A request still high in IDLE after its ack starts a new access.
//
// Ports
//   clk, rst (async, active-low)
//   if_ce_i, if_addr_i, if_data_o, if_ack_o           fetch port (read only)
//   mem_ce_i, mem_we_i, mem_sel_i, mem_addr_i,
//   mem_data_i, mem_data_o, mem_ack_o                 data port
//   stall_req_o                                       pipeline stall request
//   sram_addr_o, sram_data_o, sram_data_i, sram_data_oe_o,
//   sram_ce_n_o, sram_oe_n_o, sram_we_n_o, sram_be_n_o   SRAM pins
module ram_arbiter #(
    parameter int ADDR_W      = 20,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_ce_i,
    input  logic [31:0]       if_addr_i,
    output logic [31:0]       if_data_o,
    output logic              if_ack_o,
    input  logic              mem_ce_i,
    input  logic              mem_we_i,
    input  logic [3:0]        mem_sel_i,
    input  logic [31:0]       mem_addr_i,
    input  logic [31:0]       mem_data_i,
    output logic [31:0]       mem_data_o,
    output logic              mem_ack_o,
    output logic              stall_req_o,
    output logic [ADDR_W-1:0] sram_addr_o,
    output logic [31:0]       sram_data_o,
    input  logic [31:0]       sram_data_i,
    output logic              sram_data_oe_o,
    output logic              sram_ce_n_o,
    output logic              sram_oe_n_o,
    output logic              sram_we_n_o,
    output logic [3:0]        sram_be_n_o
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ACCESS  = 2'd1;
    localparam logic [1:0] ST_RECOVER = 2'd2;

    localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES - 1);

    logic [1:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        grant_mem_q, grant_mem_d;
    logic        we_q, we_d;
    logic [3:0]  sel_q, sel_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] if_data_q, if_data_d;
    logic [31:0] mem_data_q, mem_data_d;

    logic in_access;
    logic in_recover;

    // Only addr_q[ADDR_W+1:2] reaches the SRAM; the byte offset and any
    // bits above the SRAM size are intentionally dropped.
    logic unused_addr_bits;
    assign unused_addr_bits = ^addr_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        grant_mem_d = grant_mem_q;
        we_d        = we_q;
        sel_d       = sel_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        if_data_d   = if_data_q;
        mem_data_d  = mem_data_q;

        case (state_q)
            ST_IDLE: begin
                if (mem_ce_i) begin
                    grant_mem_d = 1'b1;
                    we_d        = mem_we_i;
                    sel_d       = mem_sel_i;
                    addr_d      = mem_addr_i;
                    wdata_d     = mem_data_i;
                    cnt_d       = 4'd0;
                    state_d     = ST_ACCESS;
                end else if (if_ce_i) begin
                    grant_mem_d = 1'b0;
                    we_d        = 1'b0;
                    sel_d       = 4'hF;
                    addr_d      = if_addr_i;
                    cnt_d       = 4'd0;
                    state_d     = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (cnt_q == LAST_CNT) begin
                    cnt_d   = 4'd0;
                    state_d = ST_RECOVER;
                    // Read data is captured on the last strobe edge, while
                    // oe_n is still low, so the SRAM output is settled.
                    if (!we_q) begin
                        if (grant_mem_q) begin
                            mem_data_d = sram_data_i;
                        end else begin
                            if_data_d = sram_data_i;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ST_RECOVER: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            grant_mem_q <= 1'b0;
            we_q        <= 1'b0;
            sel_q       <= 4'h0;
            addr_q      <= 32'h0;
            wdata_q     <= 32'h0;
            if_data_q   <= 32'h0;
            mem_data_q  <= 32'h0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            grant_mem_q <= grant_mem_d;
            we_q        <= we_d;
            sel_q       <= sel_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            if_data_q   <= if_data_d;
            mem_data_q  <= mem_data_d;
        end
    end

    // Strobes and acks decode straight from state_q, so an asynchronous
    // reset releases the SRAM bus immediately and kills any pending ack.
    assign in_access  = (state_q == ST_ACCESS);
    assign in_recover = (state_q == ST_RECOVER);

    assign sram_ce_n_o    = ~in_access;
    assign sram_oe_n_o    = ~(in_access & ~we_q);
    assign sram_we_n_o    = ~(in_access & we_q);
    assign sram_be_n_o    = in_access ? (we_q ? ~sel_q : 4'b0000) : 4'b1111;
    assign sram_data_oe_o = in_access & we_q;
    assign sram_data_o    = wdata_q;
    assign sram_addr_o    = addr_q[ADDR_W+1:2];

    assign if_ack_o   = in_recover & ~grant_mem_q;
    assign mem_ack_o  = in_recover & grant_mem_q;
    assign if_data_o  = if_data_q;
    assign mem_data_o = mem_data_q;

    assign stall_req_o = (if_ce_i & ~if_ack_o) | (mem_ce_i & ~mem_ack_o);

endmodule
